// File: rtl/decoder_2_4.sv
// 2-to-4 line decoder with enable.
// Provides a combinational one-hot (or one-cold) output and a registered copy
// qualified by a registered enable.
module decoder_2_4 #(
   // 1: outputs are one-cold (all bits inverted); 0: one-hot
   parameter bit OUT_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] e,
   input  logic       en,
   output logic [3:0] d,
   output logic [3:0] d_q,
   output logic       valid_q
);

   // Pattern seen on d/d_q when nothing is selected
   localparam logic [3:0] IdlePattern = OUT_ACTIVE_LOW ? 4'b1111 : 4'b0000;
   // XOR mask that turns the one-hot decode into the configured sense
   localparam logic [3:0] SenseMask   = {4{OUT_ACTIVE_LOW}};

   logic [3:0] onehot;

   // Decode every {en, e} combination explicitly so no X can reach d
   always_comb begin
      onehot = 4'b0000;
      case ({en, e})
         3'b000:  onehot = 4'b0000;
         3'b001:  onehot = 4'b0000;
         3'b010:  onehot = 4'b0000;
         3'b011:  onehot = 4'b0000;
         3'b100:  onehot = 4'b0001;
         3'b101:  onehot = 4'b0010;
         3'b110:  onehot = 4'b0100;
         3'b111:  onehot = 4'b1000;
         default: onehot = 4'b0000;
      endcase
   end

   // Apply output sense; independent of clk and rst
   always_comb begin
      d = onehot ^ SenseMask;
   end

   // Capture the decoded value and its qualifier; reset forces the idle pattern
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_q     <= IdlePattern;
         valid_q <= 1'b0;
      end else begin
         d_q     <= d;
         valid_q <= en;
      end
   end

endmodule

// File: tb/tb_decoder_2_4.sv
// Directed-vector bench for decoder_2_4: one active-high and one active-low
// instance driven from the same inputs.
`timescale 1ns/1ps
module tb_decoder_2_4;

   logic       clk;
   logic       rst;
   logic [1:0] e;
   logic       en;
   logic [3:0] d_hi, d_q_hi;
   logic       valid_q_hi;
   logic [3:0] d_lo, d_q_lo;
   logic       valid_q_lo;

   int unsigned vectors;
   int unsigned miscompares;

   decoder_2_4 #(.OUT_ACTIVE_LOW(1'b0)) u_dut_hi (
      .clk     (clk),
      .rst     (rst),
      .e       (e),
      .en      (en),
      .d       (d_hi),
      .d_q     (d_q_hi),
      .valid_q (valid_q_hi)
   );

   decoder_2_4 #(.OUT_ACTIVE_LOW(1'b1)) u_dut_lo (
      .clk     (clk),
      .rst     (rst),
      .e       (e),
      .en      (en),
      .d       (d_lo),
      .d_q     (d_q_lo),
      .valid_q (valid_q_lo)
   );

   // Posedges at 10, 30, 50, ...
   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, expected %b", tag, obs, exp);
      end
   endtask

   // Hand-written truth table for the active-high decode, indexed by {en, e}
   function automatic logic [3:0] expected_hot(input logic [2:0] sel);
      logic [3:0] r;
      case (sel)
         3'b100:  r = 4'b0001;
         3'b101:  r = 4'b0010;
         3'b110:  r = 4'b0100;
         3'b111:  r = 4'b1000;
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] exp_v;

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1;
      e   = 2'b00;
      en  = 1'b0;

      // Reset state
      #5;
      check_val("rst_d_q_hi", d_q_hi, 4'b0000);
      check_val("rst_valid_hi", {3'b000, valid_q_hi}, 4'b0000);
      check_val("rst_d_q_lo", d_q_lo, 4'b1111);
      check_val("rst_valid_lo", {3'b000, valid_q_lo}, 4'b0000);
      check_val("rst_d_hi_en0", d_hi, 4'b0000);
      check_val("rst_d_lo_en0", d_lo, 4'b1111);
      en = 1'b1;
      e  = 2'b01;
      #1;
      check_val("rst_d_hi_follows", d_hi, 4'b0010);
      en = 1'b0;
      #24;
      rst = 1'b0;
      tick();

      // Sweep, 50 ns apart
      en = 1'b1;
      e = 2'b00; #50; check_val("sweep_e00", d_hi, 4'b0001);
      e = 2'b01; #50; check_val("sweep_e01", d_hi, 4'b0010);
      e = 2'b10; #50; check_val("sweep_e10", d_hi, 4'b0100);
      e = 2'b11; #50; check_val("sweep_e11", d_hi, 4'b1000);
      tick();

      // Disable
      e  = 2'b11;
      en = 1'b0;
      #1;
      check_val("dis_d", d_hi, 4'b0000);
      tick();
      check_val("dis_d_q", d_q_hi, 4'b0000);
      check_val("dis_valid", {3'b000, valid_q_hi}, 4'b0000);

      // Latency: applied just after an edge
      e  = 2'b10;
      en = 1'b1;
      #1;
      check_val("lat_d_now", d_hi, 4'b0100);
      check_val("lat_d_q_before", d_q_hi, 4'b0000);
      check_val("lat_valid_before", {3'b000, valid_q_hi}, 4'b0000);
      tick();
      check_val("lat_d_q_after", d_q_hi, 4'b0100);
      check_val("lat_valid_after", {3'b000, valid_q_hi}, 4'b0001);

      // Async reset mid-cycle
      e = 2'b11;
      tick();
      check_val("ar_d_q_pre", d_q_hi, 4'b1000);
      check_val("ar_valid_pre", {3'b000, valid_q_hi}, 4'b0001);
      #5;
      rst = 1'b1;
      #1;
      check_val("ar_d_q", d_q_hi, 4'b0000);
      check_val("ar_valid", {3'b000, valid_q_hi}, 4'b0000);
      check_val("ar_d_unchanged", d_hi, 4'b1000);
      check_val("ar_d_q_lo", d_q_lo, 4'b1111);
      check_val("ar_d_lo_unchanged", d_lo, 4'b0111);
      #2;
      rst = 1'b0;
      tick();
      check_val("ar_resume_d_q", d_q_hi, 4'b1000);
      check_val("ar_resume_valid", {3'b000, valid_q_hi}, 4'b0001);

      // Active-low build
      en = 1'b1;
      e  = 2'b01;
      #1;
      check_val("lo_en1_e01", d_lo, 4'b1101);
      en = 1'b0;
      #1;
      check_val("lo_en0", d_lo, 4'b1111);
      tick();

      // Exhaustive {en, e}
      for (int i = 0; i < 8; i++) begin
         logic [2:0] sel;
         sel = 3'(i);
         en  = sel[2];
         e   = sel[1:0];
         exp_v = expected_hot(sel);
         #1;
         check_val($sformatf("ex%0d_d_hi", i), d_hi, exp_v);
         check_val($sformatf("ex%0d_d_lo", i), d_lo, ~exp_v);
         check_val($sformatf("ex%0d_ones_hi", i), 4'($countones(d_hi)), {3'b000, sel[2]});
         check_val($sformatf("ex%0d_ones_lo", i), 4'($countones(~d_lo)), {3'b000, sel[2]});
         tick();
         check_val($sformatf("ex%0d_d_q_hi", i), d_q_hi, exp_v);
         check_val($sformatf("ex%0d_d_q_lo", i), d_q_lo, ~exp_v);
         check_val($sformatf("ex%0d_valid", i), {3'b000, valid_q_hi}, {3'b000, sel[2]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
